// File: rtl/mluart_pkg.sv
// -----------------------------------------------------------------------------
// mluart_pkg
// Shared definitions for the MLUART transmit path:
//   - parity mode encodings carried on parity_mode[1:0]
//   - transmitter state enum
//   - parity helpers (data is zero-extended to the widest legal character,
//     which leaves the XOR reduction unchanged for narrower characters)
// -----------------------------------------------------------------------------
package mluart_pkg;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b01;
    localparam logic [1:0] PARITY_ODD  = 2'b10;

    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Parity bit for a character: XOR of the data bits for even parity,
    // its inverse for odd parity.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic [1:0]               mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

    // Encoding 11 is treated the same as "none".
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/mluart_tx_fifo.sv
// -----------------------------------------------------------------------------
// mluart_tx_fifo
// Small synchronous FIFO feeding the transmitter.
// Ports:
//   clk        clock
//   srst       synchronous active-high reset, flushes the queue
//   push       write request; refused while full (even if a pop coincides)
//   push_data  word to write
//   pop        read request; ignored while empty
//   pop_data   head of queue (valid whenever empty is low)
//   full/empty status flags, derived from the registered level
//   level      number of stored words
// -----------------------------------------------------------------------------
module mluart_tx_fifo #(
    parameter  int WIDTH   = 8,
    parameter  int DEPTH   = 4,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int LEVEL_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   pop_data,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [LEVEL_W-1:0] level_reg;
    logic [LEVEL_W-1:0] level_next;
    logic               push_ok;
    logic               pop_ok;

    assign full     = (level_reg == LEVEL_W'(DEPTH));
    assign empty    = (level_reg == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    // Head is read directly so the serializer can load it on the pop edge.
    assign pop_data = mem[rd_ptr_reg];
    assign level    = level_reg;

    always_comb begin
        level_next = level_reg;
        case ({push_ok, pop_ok})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            level_reg <= level_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/mluart_tx_cfg.sv
// -----------------------------------------------------------------------------
// mluart_tx_cfg
// Buffered UART transmitter with configurable character width, run-time
// parity (none/even/odd) and stop-bit count, and a configurable number of
// baud-enable pulses per bit.
// Ports:
//   CLK_100MHZ          system clock
//   reset               synchronous active-high reset (aborts any frame)
//   clk_en_baud_os      one-cycle enable at OVERSAMPLE x baud
//   data_in/data_valid  character push; accepted when data_valid && data_ready
//   data_ready          queue not full (low while reset is high)
//   parity_mode         00 none, 01 even, 10 odd, 11 none (latched per frame)
//   two_stop            0 one stop bit, 1 two stop bits (latched per frame)
//   UART_TX             registered serial output, idles high
//   tx_busy             a frame is on the line
//   send_data_complete  one-clock pulse at the end of each frame
//   fifo_level          number of queued characters
// -----------------------------------------------------------------------------
module mluart_tx_cfg #(
    parameter  int DATA_BITS  = 8,
    parameter  int OVERSAMPLE = 16,
    parameter  int FIFO_DEPTH = 4,
    localparam int LEVEL_W    = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 CLK_100MHZ,
    input  logic                 reset,
    input  logic                 clk_en_baud_os,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic                 UART_TX,
    output logic                 tx_busy,
    output logic                 send_data_complete,
    output logic [LEVEL_W-1:0]   fifo_level
);
    import mluart_pkg::*;

    localparam logic [5:0] OS_LAST  = 6'(OVERSAMPLE - 1);
    localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);

    tx_state_t            state_reg,    state_next;
    logic [5:0]           os_cnt_reg,   os_cnt_next;
    logic [3:0]           bit_cnt_reg,  bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg,    shift_next;
    logic                 par_bit_reg,  par_bit_next;
    logic                 par_en_reg,   par_en_next;
    logic                 two_stop_reg, two_stop_next;
    logic                 stop_cnt_reg, stop_cnt_next;
    logic                 tx_reg,       tx_next;
    logic                 done_reg,     done_next;

    logic                 start_frame;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;

    mluart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK_100MHZ),
        .srst      (reset),
        .push      (data_valid),
        .push_data (data_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Gated by reset so producers see "not ready" while the queue is flushed.
    assign data_ready         = !fifo_full && !reset;
    assign UART_TX            = tx_reg;
    assign tx_busy            = (state_reg != ST_IDLE);
    assign send_data_complete = done_reg;

    always_comb begin
        state_next    = state_reg;
        os_cnt_next   = os_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        par_bit_next  = par_bit_reg;
        par_en_next   = par_en_reg;
        two_stop_next = two_stop_reg;
        stop_cnt_next = stop_cnt_reg;
        tx_next       = tx_reg;
        done_next     = 1'b0;
        start_frame   = 1'b0;
        fifo_pop      = 1'b0;

        if (clk_en_baud_os) begin
            if (state_reg == ST_IDLE) begin
                start_frame = !fifo_empty;
            end else if (os_cnt_reg == OS_LAST) begin
                // End of the current bit period: the next level goes out now.
                os_cnt_next = '0;
                case (state_reg)
                    ST_START: begin
                        state_next   = ST_DATA;
                        bit_cnt_next = '0;
                        tx_next      = shift_reg[0];
                    end
                    ST_DATA: begin
                        if (bit_cnt_reg == BIT_LAST) begin
                            if (par_en_reg) begin
                                state_next = ST_PARITY;
                                tx_next    = par_bit_reg;
                            end else begin
                                state_next    = ST_STOP;
                                stop_cnt_next = 1'b0;
                                tx_next       = 1'b1;
                            end
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                            shift_next   = shift_reg >> 1;
                            tx_next      = shift_reg[1];
                        end
                    end
                    ST_PARITY: begin
                        state_next    = ST_STOP;
                        stop_cnt_next = 1'b0;
                        tx_next       = 1'b1;
                    end
                    ST_STOP: begin
                        if (two_stop_reg && !stop_cnt_reg) begin
                            stop_cnt_next = 1'b1;
                        end else begin
                            done_next = 1'b1;
                            if (!fifo_empty) begin
                                // Chain straight into the next start bit.
                                start_frame = 1'b1;
                            end else begin
                                state_next = ST_IDLE;
                                tx_next    = 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                        tx_next    = 1'b1;
                    end
                endcase
            end else begin
                os_cnt_next = os_cnt_reg + 1'b1;
            end
        end

        // Load a new character and freeze the frame format for its duration.
        if (start_frame) begin
            fifo_pop      = 1'b1;
            shift_next    = fifo_data;
            par_en_next   = parity_enabled(parity_mode);
            par_bit_next  = parity_bit(MAX_DATA_BITS'(fifo_data), parity_mode);
            two_stop_next = two_stop;
            state_next    = ST_START;
            os_cnt_next   = '0;
            tx_next       = 1'b0;
        end
    end

    always_ff @(posedge CLK_100MHZ) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            os_cnt_reg   <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            par_bit_reg  <= 1'b0;
            par_en_reg   <= 1'b0;
            two_stop_reg <= 1'b0;
            stop_cnt_reg <= 1'b0;
            tx_reg       <= 1'b1;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            os_cnt_reg   <= os_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            par_bit_reg  <= par_bit_next;
            par_en_reg   <= par_en_next;
            two_stop_reg <= two_stop_next;
            stop_cnt_reg <= stop_cnt_next;
            tx_reg       <= tx_next;
            done_reg     <= done_next;
        end
    end

endmodule

// File: tb/tb_mluart_tx_cfg.sv
// -----------------------------------------------------------------------------
// tb_mluart_tx_cfg
// Scoreboard bench: each accepted push queues the expected line pattern of its
// frame; a line monitor pops an entry when a start bit appears and compares
// every bit at mid-period, the frame length and the completion pulse.
// -----------------------------------------------------------------------------
module tb_mluart_tx_cfg;

    localparam int DB    = 8;
    localparam int OS    = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [DB-1:0] data_in = '0;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic [1:0]    parity_mode = 2'b00;
    logic          two_stop = 1'b0;
    logic          uart_tx;
    logic          tx_busy;
    logic          done;
    logic [LW-1:0] fifo_level;

    always #5 clk = ~clk;

    mluart_tx_cfg #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (OS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK_100MHZ         (clk),
        .reset              (reset),
        .clk_en_baud_os     (en),
        .data_in            (data_in),
        .data_valid         (data_valid),
        .data_ready         (data_ready),
        .parity_mode        (parity_mode),
        .two_stop           (two_stop),
        .UART_TX            (uart_tx),
        .tx_busy            (tx_busy),
        .send_data_complete (done),
        .fifo_level         (fifo_level)
    );

    typedef struct packed {
        logic [11:0]   bits;   // expected line level per bit period
        logic [3:0]    nbits;
        logic [DB-1:0] data;
    } frame_t;

    frame_t exp_q[$];
    frame_t cur;

    int errors = 0;
    int checks = 0;
    bit mon_active = 1'b0;
    int mon_cnt = 0;
    int model_level = 0;
    int done_cnt = 0;
    int frame_cnt = 0;
    bit spurious_seen = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic frame_t make_frame(input logic [DB-1:0] d, input logic [1:0] pm, input logic ts);
        frame_t f;
        int n;
        f.bits = '1;
        f.data = d;
        n = 0;
        f.bits[n] = 1'b0; n++;
        for (int i = 0; i < DB; i++) begin
            f.bits[n] = d[i]; n++;
        end
        if (pm == 2'b01) begin
            f.bits[n] = ^d; n++;
        end else if (pm == 2'b10) begin
            f.bits[n] = ~(^d); n++;
        end
        f.bits[n] = 1'b1; n++;
        if (ts) begin
            f.bits[n] = 1'b1; n++;
        end
        f.nbits = 4'(n);
        return f;
    endfunction

    // Called after every enable edge.
    task automatic monitor();
        if (mon_active) begin
            mon_cnt++;
            if (mon_cnt == int'(cur.nbits) * OS) begin
                check_val("done_at_end", done, 1);
                frame_cnt++;
                mon_active = 1'b0;
                $display("frame %0d data=0x%0h bits=%0d enables=%0d", frame_cnt, cur.data, cur.nbits, mon_cnt);
                if (exp_q.size() > 0) check_val("b2b_start", uart_tx, 0);
            end else if (mon_cnt % OS == OS / 2) begin
                check_val($sformatf("bit%0d_of_0x%0h", mon_cnt / OS, cur.data), uart_tx, cur.bits[mon_cnt / OS]);
            end
        end
        if (!mon_active && uart_tx == 1'b0) begin
            if (exp_q.size() == 0) begin
                if (!spurious_seen) check_val("unexpected_start", 1, 0);
                spurious_seen = 1'b1;
            end else begin
                cur = exp_q.pop_front();
                mon_active = 1'b1;
                mon_cnt = 0;
                model_level--;
            end
        end
    endtask

    task automatic cycle(input bit e, input bit push, input logic [DB-1:0] d);
        bit accept;
        en = e;
        data_valid = push;
        data_in = d;
        accept = push && (model_level < DEPTH);
        if (push) check_val("data_ready", data_ready, accept);
        @(posedge clk);
        #1;
        en = 1'b0;
        data_valid = 1'b0;
        if (done) done_cnt++;
        if (e) monitor();
        // A push on this edge is not visible to the serializer until later.
        if (accept) begin
            exp_q.push_back(make_frame(d, parity_mode, two_stop));
            model_level++;
        end
    endtask

    task automatic push_word(input logic [DB-1:0] d);
        cycle(1'b0, 1'b1, d);
    endtask

    task automatic run_en(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b0, '0);
            cycle(1'b0, 1'b0, '0);
        end
    endtask

    task automatic run_idle(input int max_en);
        int k;
        k = 0;
        while ((mon_active || exp_q.size() > 0 || tx_busy) && k < max_en) begin
            cycle(1'b1, 1'b0, '0);
            cycle(1'b0, 1'b0, '0);
            k++;
        end
        if (mon_active || exp_q.size() > 0 || tx_busy) check_val("idle_timeout", 1, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int f0;

        // Reset state
        reset = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, '0);
        check_val("rst_tx", uart_tx, 1);
        check_val("rst_busy", tx_busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_level", fifo_level, 0);
        check_val("rst_ready", data_ready, 0);
        reset = 1'b0;
        cycle(1'b0, 1'b0, '0);
        check_val("ready_after_rst", data_ready, 1);

        // 8N1, 0x55
        parity_mode = 2'b00; two_stop = 1'b0;
        d0 = done_cnt;
        push_word(8'h55);
        cycle(1'b1, 1'b0, '0);
        check_val("start_latency", uart_tx, 0);
        check_val("busy_in_frame", tx_busy, 1);
        cycle(1'b0, 1'b0, '0);
        run_idle(400);
        check_val("n1_done_count", done_cnt - d0, 1);

        // 8E1 then 8O1, 0xA3
        d0 = done_cnt;
        parity_mode = 2'b01;
        push_word(8'hA3);
        run_idle(400);
        parity_mode = 2'b10;
        push_word(8'hA3);
        run_idle(400);
        check_val("parity_done_count", done_cnt - d0, 2);

        // Odd parity, two stop bits, format changed mid-frame
        d0 = done_cnt;
        parity_mode = 2'b10; two_stop = 1'b1;
        push_word(8'h41);
        run_en(30);
        parity_mode = 2'b00; two_stop = 1'b0;
        run_idle(400);
        check_val("o2_done_count", done_cnt - d0, 1);

        // Fill the queue with enables held low; 5th push refused
        d0 = done_cnt; f0 = frame_cnt;
        parity_mode = 2'b00; two_stop = 1'b0;
        for (int i = 0; i < 5; i++) push_word(8'h10 + 8'(i));
        check_val("full_level", fifo_level, 4);
        check_val("full_ready", data_ready, 0);
        run_idle(1000);
        check_val("b2b_done_count", done_cnt - d0, 4);
        check_val("b2b_frames", frame_cnt - f0, 4);
        check_val("drained_level", fifo_level, 0);

        // Reset in the middle of a frame
        push_word(8'h3C);
        push_word(8'h5A);
        d0 = done_cnt;
        run_en(50);
        reset = 1'b1;
        cycle(1'b0, 1'b0, '0);
        check_val("abort_tx", uart_tx, 1);
        check_val("abort_level", fifo_level, 0);
        check_val("abort_ready", data_ready, 0);
        check_val("abort_busy", tx_busy, 0);
        mon_active = 1'b0;
        exp_q.delete();
        model_level = 0;
        cycle(1'b0, 1'b0, '0);
        reset = 1'b0;
        cycle(1'b0, 1'b0, '0);
        run_en(300);
        check_val("abort_no_done", done_cnt - d0, 0);
        push_word(8'h81);
        run_idle(400);
        check_val("after_abort_done", done_cnt - d0, 1);

        // Push on the same edge the last stop period ends
        d0 = done_cnt;
        push_word(8'hC3);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        run_en(159);
        cycle(1'b1, 1'b1, 8'h99);
        check_val("edge_push_idle_tx", uart_tx, 1);
        check_val("edge_push_idle_busy", tx_busy, 0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        check_val("edge_push_next_start", uart_tx, 0);
        cycle(1'b0, 1'b0, '0);
        run_idle(400);
        check_val("edge_push_done_count", done_cnt - d0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
